// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, reset PC, canonical NOP and
// the fetch-stage FSM encoding.
package riscv_pkg;

  localparam int          XLEN     = 64;
  localparam int          ILEN     = 32;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: PC handshake from the PC unit, instruction memory
// request/response, and the decode-side entry handshake.
// master = fetch stage, slave = its environment (PC unit, memory, decode).
interface ifetch_if import riscv_pkg::*; #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic [XLEN-1:0] pc_i;
  logic            pc_valid_i;
  logic            pc_ready_o;
  logic            flush_i;
  logic            imem_req_valid_o;
  logic            imem_req_ready_i;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_rsp_valid_i;
  logic [ILEN-1:0] imem_rsp_data_i;
  logic            id_valid_o;
  logic            id_ready_i;
  logic [XLEN-1:0] id_pc_o;
  logic [ILEN-1:0] id_inst_o;
  logic            id_misalign_o;

  modport master (
    input  pc_i, pc_valid_i, flush_i, imem_req_ready_i,
           imem_rsp_valid_i, imem_rsp_data_i, id_ready_i,
    output pc_ready_o, imem_req_valid_o, imem_addr_o,
           id_valid_o, id_pc_o, id_inst_o, id_misalign_o
  );

  modport slave (
    output pc_i, pc_valid_i, flush_i, imem_req_ready_i,
           imem_rsp_valid_i, imem_rsp_data_i, id_ready_i,
    input  pc_ready_o, imem_req_valid_o, imem_addr_o,
           id_valid_o, id_pc_o, id_inst_o, id_misalign_o
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of {pc, inst, misalign} entries toward decode.
// The head entry is held in dedicated output registers so decode sees
// flop-driven signals; flush empties the FIFO and wins over a same-cycle push.
module ifetch_fifo import riscv_pkg::*; #(
  parameter  int XLEN  = riscv_pkg::XLEN,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [ILEN-1:0] push_inst,
  input  logic            push_mis,
  input  logic            pop,
  output logic            head_vld,
  output logic [XLEN-1:0] head_pc,
  output logic [ILEN-1:0] head_inst,
  output logic            head_mis,
  output logic [CW-1:0]   count
);

  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [ILEN-1:0] mem_inst [DEPTH];
  logic            mem_mis  [DEPTH];

  logic [AW-1:0] rd_q, wr_q, rd_nxt_idx;
  logic [CW-1:0] count_q, count_nxt;
  logic          pop_en, do_push, load_push, load_mem;

  assign pop_en     = pop && (count_q != '0);
  assign do_push    = push && !flush;
  assign rd_nxt_idx = rd_q + AW'(1);
  // The pushed entry becomes the head if nothing else will be in front of it.
  assign load_push  = do_push && ((count_q == '0) || ((count_q == CW'(1)) && pop_en));
  assign load_mem   = !flush && pop_en && (count_q > CW'(1));
  assign count      = count_q;

  // Next occupancy after flush/push/pop.
  always_comb begin
    count_nxt = count_q;
    if (flush) count_nxt = '0;
    else       count_nxt = count_q + CW'(do_push) - CW'(pop_en);
  end

  // Pointers, occupancy and head-valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      head_vld <= 1'b0;
    end else begin
      if (flush) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        rd_q <= rd_q + AW'(pop_en);
        wr_q <= wr_q + AW'(do_push);
      end
      count_q  <= count_nxt;
      head_vld <= (count_nxt != '0);
    end
  end

  // Head output registers: load from the push path or the next stored entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_pc   <= '0;
      head_inst <= '0;
      head_mis  <= 1'b0;
    end else if (load_push) begin
      head_pc   <= push_pc;
      head_inst <= push_inst;
      head_mis  <= push_mis;
    end else if (load_mem) begin
      head_pc   <= mem_pc[rd_nxt_idx];
      head_inst <= mem_inst[rd_nxt_idx];
      head_mis  <= mem_mis[rd_nxt_idx];
    end
  end

  // Entry storage; written on every accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_pc[wr_q]   <= push_pc;
      mem_inst[wr_q] <= push_inst;
      mem_mis[wr_q]  <= push_mis;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: accepts a PC from the PC unit, issues one
// instruction-memory read per PC (one transaction outstanding at most) and
// buffers {pc, inst} pairs toward decode. A redirect flush empties the buffer
// and marks any in-flight response for discard via the kill flag.
// Optional build macro: IFETCH_MISALIGN_CHK_EN -- misaligned PCs skip memory
// and are queued as a NOP flagged with id_misalign_o.
module ifetch import riscv_pkg::*; #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int FIFO_DEPTH = 2
) (
  input logic      clk,
  input logic      rst_n,
  ifetch_if.master bus
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  ifetch_state_e   state_q, state_nxt;
  logic            kill_q;
  logic [XLEN-1:0] addr_q;
  logic [CW-1:0]   fifo_count;

  logic            pc_ready, req_valid, accept, pc_mis;
  logic            push;
  logic [XLEN-1:0] push_pc;
  logic [ILEN-1:0] push_inst;
  logic            push_mis;

`ifdef IFETCH_MISALIGN_CHK_EN
  assign pc_mis = (bus.pc_i[1:0] != 2'b00);
`else
  assign pc_mis = 1'b0;
`endif

  assign accept = pc_ready && bus.pc_valid_i;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // FSM next-state: accept -> request -> wait for the single response.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept && !pc_mis)        state_nxt = REQ;
      REQ:     if (bus.imem_req_ready_i)     state_nxt = WAIT;
      WAIT:    if (bus.imem_rsp_valid_i)     state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // FSM outputs: PC back-pressure, request valid and FIFO push selection.
  always_comb begin
    pc_ready  = 1'b0;
    req_valid = 1'b0;
    push      = 1'b0;
    push_pc   = addr_q;
    push_inst = bus.imem_rsp_data_i;
    push_mis  = 1'b0;
    case (state_q)
      IDLE: begin
        // Space is reserved here, so the later push can never overflow.
        pc_ready = rst_n && !bus.flush_i && !kill_q && (fifo_count < DEPTH_C);
        if (pc_ready && bus.pc_valid_i && pc_mis) begin
          push      = 1'b1;
          push_pc   = bus.pc_i;
          push_inst = INST_NOP;
          push_mis  = 1'b1;
        end
      end
      REQ:     req_valid = 1'b1;
      WAIT:    push      = bus.imem_rsp_valid_i && !kill_q;
      default: ;
    endcase
  end

  // Kill flag: a flush while a transaction is outstanding discards its response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_q <= 1'b0;
    end else if (state_q == WAIT && bus.imem_rsp_valid_i) begin
      // The response arriving now is consumed (and dropped if killed or flushed).
      kill_q <= 1'b0;
    end else if (bus.flush_i && (state_q == REQ || state_q == WAIT)) begin
      kill_q <= 1'b1;
    end
  end

  // Request address: captured at accept, stable through the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   addr_q <= '0;
    else if (accept && !pc_mis)   addr_q <= bus.pc_i;
  end

  ifetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush_i),
    .push      (push),
    .push_pc   (push_pc),
    .push_inst (push_inst),
    .push_mis  (push_mis),
    .pop       (bus.id_ready_i),
    .head_vld  (bus.id_valid_o),
    .head_pc   (bus.id_pc_o),
    .head_inst (bus.id_inst_o),
    .head_mis  (bus.id_misalign_o),
    .count     (fifo_count)
  );

  assign bus.pc_ready_o       = pc_ready;
  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_addr_o      = addr_q;

endmodule
